// File: rtl/adder_seq_pkg.sv
// Shared state encoding and slice width for the serial slice adder.
package adder_seq_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_slice4.sv
// Combinational 4-bit ripple slice; also exposes the carry into bit 3 so the
// top slice can derive signed overflow.
module adder_slice4
  import adder_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout,
  output logic               c3
);

  logic [3:0] lo;
  logic [1:0] hi;

  always_comb begin
    lo   = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
    hi   = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, lo[3]};
    s    = {hi[0], lo[2:0]};
    cout = hi[1];
    c3   = lo[3];
  end

endmodule

// File: rtl/adder_sequencer.sv
// Serial WIDTH-bit adder: one shared 4-bit slice, LSB slice first, one slice per cycle.
// Define ADDER_SEQUENCER_SUB_EN to add a 'sub' port selecting a-b.
module adder_sequencer
  import adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef ADDER_SEQUENCER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int unsigned N     = WIDTH / SLICE_W;
  localparam int unsigned IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("adder_sequencer: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               co_q, co_d, ov_q, ov_d;
  logic               sub_q, sub_d;
  logic               sub_in;

`ifdef ADDER_SEQUENCER_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  int unsigned        base;
  logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
  logic               sl_cout, sl_c3;

  always_comb begin
    base = SLICE_W * 32'(idx_q);
    sl_a = a_q[base +: SLICE_W];
    sl_b = sub_q ? ~b_q[base +: SLICE_W] : b_q[base +: SLICE_W];
  end

  adder_slice4 u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_cout),
    .c3   (sl_c3)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ov_d    = ov_q;
    sub_d   = sub_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub_in;
          idx_d   = '0;
          carry_d = sub_in; // subtraction is a + ~b + 1
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[base +: SLICE_W] = sl_s;
        carry_d = sl_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          idx_d   = '0;
          sum_d   = res_d;
          co_d    = sl_cout;
          ov_d    = sl_c3 ^ sl_cout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      sub_q   <= sub_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign carryout = co_q;
  assign overflow = ov_q;

endmodule

// File: tb/tb_adder_sequencer.sv
// Randomized and directed checks of adder_sequencer (WIDTH=16) against an
// arithmetic reference model.
module tb_adder_sequencer;

  localparam int unsigned W = 16;
  localparam int unsigned N = W / 4;
`ifdef ADDER_SEQUENCER_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carryout, overflow;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_sum = '0;
  logic         exp_co = 1'b0;
  logic         exp_ov = 1'b0;

  adder_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef ADDER_SEQUENCER_SUB_EN
    .sub      (sub),
`endif
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryout (carryout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on the whole operands.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W:0] full;
    if (s) begin
      exp_sum = x - y;
      exp_co  = (x >= y);
      exp_ov  = (x[W-1] != y[W-1]) && (exp_sum[W-1] != x[W-1]);
    end else begin
      full    = {1'b0, x} + {1'b0, y};
      exp_sum = full[W-1:0];
      exp_co  = full[W];
      exp_ov  = (x[W-1] == y[W-1]) && (exp_sum[W-1] != x[W-1]);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".sum"}, 32'(sum), 32'(exp_sum));
    check({tag, ".co"}, 32'(carryout), 32'(exp_co));
    check({tag, ".ov"}, 32'(overflow), 32'(exp_ov));
  endtask

  // One transaction; 'poke' holds start high with other operands through RUN and DONE.
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input bit poke);
    logic [W-1:0] prev;
    int n;
    prev  = exp_sum;
    start = 1'b1;
    a     = x;
    b     = y;
    sub   = s;
    step();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    sub   = SUB_ON ? 1'($urandom) : 1'b0;
    n = 0;
    while (!done && n < 20) begin
      check({tag, ".busy_run"}, 32'(busy), 32'd1);
      check({tag, ".sum_hold"}, 32'(sum), 32'(prev));
      if (poke && n == 1) begin
        start = 1'b1;
        a     = 16'h1111;
        b     = 16'h1111;
      end
      step();
      n++;
    end
    model(x, y, s);
    check({tag, ".latency"}, 32'(n), 32'(N));
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    check({tag, ".sum"}, 32'(sum), 32'(exp_sum));
    check({tag, ".co"}, 32'(carryout), 32'(exp_co));
    check({tag, ".ov"}, 32'(overflow), 32'(exp_ov));
    step();
    start = 1'b0;
    check_idle({tag, ".after"});
  endtask

  initial begin
    #1;
    check_idle("reset0");
    step();
    step();
    reset = 1'b0;

    run_op("add_2_4", 16'h0002, 16'h0004, 1'b0, 1'b0);
    run_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op("add_8000_8000_poke", 16'h8000, 16'h8000, 1'b0, 1'b1);

    // Mid-RUN reset must discard the operation and clear outputs immediately.
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h4321;
    step();
    start = 1'b0;
    step();
    step();
    check("pre_reset.busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    exp_sum = '0;
    exp_co  = 1'b0;
    exp_ov  = 1'b0;
    check_idle("async_reset");
    step();
    reset = 1'b0;
    run_op("after_reset", 16'h0010, 16'h0020, 1'b0, 1'b0);

`ifdef ADDER_SEQUENCER_SUB_EN
    run_op("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b0);
    run_op("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] rx, ry;
      rx = W'($urandom);
      ry = W'($urandom);
      if (i % 6 == 0) rx = 16'h8000 | W'($urandom_range(0, 3));
      if (i % 6 == 1) ry = 16'hFFFF;
      run_op($sformatf("rand%0d", i), rx, ry, SUB_ON ? 1'($urandom) : 1'b0, (i % 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
